vc_arbiter: RTL and testbench

- Weighted round-robin scheduler between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) of the interconnect device.
- Each cycle it selects at most one VC head word, pops it, and one cycle later pushes it into D0 or D1 according to the word's destination bit.
- Respects almost-full backpressure per destination. Enabled by the device FSM while in its active state.

---
 rtl/vc_arbiter.sv | 250 +++++++++++++++++++++++++
 tb/tb_vc_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_arbiter.sv
// -----------------------------------------------------------------------------
// vc_arbiter
// Weighted round-robin scheduler moving words from two show-ahead virtual
// channel FIFOs (VC0, VC1) into two destination FIFOs (D0, D1). At most one VC
// head word is popped per cycle; the word is pushed into D0 or D1 (chosen by
// bit DEST_BIT of the word) exactly one cycle after its pop.
//
// Optional build macro: ARB_STATS_EN
//   defined   -> per-VC saturating grant counters drive grant_cnt_vc0/1
//   undefined -> no counters; grant_cnt_vc0/1 are tied to 0
//
// Ports
//   clk               clock
//   reset             asynchronous reset, active low
//   enable            arbitration permitted (device FSM active state)
//   weight_vc0/1      consecutive grants allowed per VC (0 behaves as 1)
//   vc0/1_empty       VC FIFO empty flags
//   vc0/1_data        VC FIFO head words (show-ahead)
//   d0/1_almost_full  destination pause
//   pop_vc0/1         combinational pops of the VC FIFOs
//   push_d0/1         registered pushes into the destination FIFOs
//   data_out          registered word for the destination FIFOs
//   arb_idle          no pop this cycle and no push in progress
//   grant_cnt_vc0/1   grant statistics (ARB_STATS_EN only, else 0)
// -----------------------------------------------------------------------------
module vc_arbiter #(
    parameter int DATA_W   = 6,
    parameter int DEST_BIT = 4,
    parameter int WEIGHT_W = 3,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [WEIGHT_W-1:0] weight_vc0,
    input  logic [WEIGHT_W-1:0] weight_vc1,
    input  logic                vc0_empty,
    input  logic                vc1_empty,
    input  logic [DATA_W-1:0]   vc0_data,
    input  logic [DATA_W-1:0]   vc1_data,
    input  logic                d0_almost_full,
    input  logic                d1_almost_full,
    output logic                pop_vc0,
    output logic                pop_vc1,
    output logic                push_d0,
    output logic                push_d1,
    output logic [DATA_W-1:0]   data_out,
    output logic                arb_idle,
    output logic [CNT_W-1:0]    grant_cnt_vc0,
    output logic [CNT_W-1:0]    grant_cnt_vc1
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_e;

    // A programmed weight of zero is served as a weight of one.
    function automatic logic [WEIGHT_W:0] eff_weight(input logic [WEIGHT_W-1:0] w);
        logic [WEIGHT_W:0] r;
        if (w == {WEIGHT_W{1'b0}}) begin
            r = {{WEIGHT_W{1'b0}}, 1'b1};
        end else begin
            r = {1'b0, w};
        end
        return r;
    endfunction

    state_e              state_q, state_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;
    logic                last_grant_q, last_grant_d;   // 1'b1 = VC1 served last
    logic                push_d0_q, push_d1_q;
    logic [DATA_W-1:0]   data_q;

    logic                vc0_af_s, vc1_af_s;
    logic                elig0_s, elig1_s;
    logic [WEIGHT_W:0]   w0_eff_s, w1_eff_s;
    logic [WEIGHT_W:0]   credit_inc_s;
    logic                pop0_s, pop1_s;
    logic                pop0_g_s, pop1_g_s, pop_any_s;
    logic [DATA_W-1:0]   sel_word_s;

    // Each VC looks only at the pause flag of its own head word's destination,
    // so a blocked VC never stalls the other one.
    assign vc0_af_s = vc0_data[DEST_BIT] ? d1_almost_full : d0_almost_full;
    assign vc1_af_s = vc1_data[DEST_BIT] ? d1_almost_full : d0_almost_full;
    assign elig0_s  = ~vc0_empty & ~vc0_af_s;
    assign elig1_s  = ~vc1_empty & ~vc1_af_s;

    assign w0_eff_s     = eff_weight(weight_vc0);
    assign w1_eff_s     = eff_weight(weight_vc1);
    assign credit_inc_s = {1'b0, credit_q} + {{WEIGHT_W{1'b0}}, 1'b1};

    // Arbitration FSM: next state, credit and pop selection.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        pop0_s   = 1'b0;
        pop1_s   = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    credit_d = {WEIGHT_W{1'b0}};
                    if (last_grant_q) begin
                        state_d = ST_GNT0;
                    end else begin
                        state_d = ST_GNT1;
                    end
                end
                ST_GNT0: begin
                    if (elig0_s) begin
                        pop0_s = 1'b1;
                        if (credit_inc_s >= w0_eff_s) begin
                            // Burst finished; keep VC0 if VC1 cannot use the slot.
                            credit_d = {WEIGHT_W{1'b0}};
                            if (elig1_s) begin
                                state_d = ST_GNT1;
                            end else begin
                                state_d = ST_GNT0;
                            end
                        end else begin
                            credit_d = credit_inc_s[WEIGHT_W-1:0];
                        end
                    end else if (elig1_s) begin
                        pop1_s   = 1'b1;
                        state_d  = ST_GNT1;
                        credit_d = {{(WEIGHT_W-1){1'b0}}, 1'b1};
                    end else begin
                        state_d  = state_q;
                        credit_d = credit_q;
                    end
                end
                ST_GNT1: begin
                    if (elig1_s) begin
                        pop1_s = 1'b1;
                        if (credit_inc_s >= w1_eff_s) begin
                            credit_d = {WEIGHT_W{1'b0}};
                            if (elig0_s) begin
                                state_d = ST_GNT0;
                            end else begin
                                state_d = ST_GNT1;
                            end
                        end else begin
                            credit_d = credit_inc_s[WEIGHT_W-1:0];
                        end
                    end else if (elig0_s) begin
                        pop0_s   = 1'b1;
                        state_d  = ST_GNT0;
                        credit_d = {{(WEIGHT_W-1){1'b0}}, 1'b1};
                    end else begin
                        state_d  = state_q;
                        credit_d = credit_q;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    credit_d = {WEIGHT_W{1'b0}};
                end
            endcase
        end
    end

    // Pops are gated by reset so they drop the moment reset is asserted,
    // even between clock edges.
    assign pop0_g_s   = pop0_s & reset;
    assign pop1_g_s   = pop1_s & reset;
    assign pop_any_s  = pop0_g_s | pop1_g_s;
    assign sel_word_s = pop1_g_s ? vc1_data : vc0_data;

    // Remember which VC was served last so a restart favours the other one.
    always_comb begin
        if (pop0_g_s) begin
            last_grant_d = 1'b0;
        end else if (pop1_g_s) begin
            last_grant_d = 1'b1;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // FSM state, credit and last-grant registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            credit_q     <= {WEIGHT_W{1'b0}};
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Output stage: popped word is registered and pushed one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            push_d0_q <= 1'b0;
            push_d1_q <= 1'b0;
            data_q    <= {DATA_W{1'b0}};
        end else begin
            push_d0_q <= pop_any_s & ~sel_word_s[DEST_BIT];
            push_d1_q <= pop_any_s &  sel_word_s[DEST_BIT];
            if (pop_any_s) begin
                data_q <= sel_word_s;
            end else begin
                data_q <= data_q;
            end
        end
    end

    assign pop_vc0  = pop0_g_s;
    assign pop_vc1  = pop1_g_s;
    assign push_d0  = push_d0_q;
    assign push_d1  = push_d1_q;
    assign data_out = data_q;
    assign arb_idle = ~pop_any_s & ~push_d0_q & ~push_d1_q;

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    // Saturating grant counters, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt0_q <= {CNT_W{1'b0}};
            cnt1_q <= {CNT_W{1'b0}};
        end else begin
            if (pop0_g_s && (cnt0_q != {CNT_W{1'b1}})) begin
                cnt0_q <= cnt0_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt0_q <= cnt0_q;
            end
            if (pop1_g_s && (cnt1_q != {CNT_W{1'b1}})) begin
                cnt1_q <= cnt1_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt1_q <= cnt1_q;
            end
        end
    end

    assign grant_cnt_vc0 = cnt0_q;
    assign grant_cnt_vc1 = cnt1_q;
`else
    assign grant_cnt_vc0 = {CNT_W{1'b0}};
    assign grant_cnt_vc1 = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_vc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vc_arbiter
// Self-checking bench for vc_arbiter: a table of single-cycle eligibility
// vectors, hand-written multi-cycle sequences, and a randomized run checked
// against a behavioural model of the weighted round-robin rules.
// -----------------------------------------------------------------------------
module tb_vc_arbiter;

    localparam int DATA_W   = 6;
    localparam int DEST_BIT = 4;
    localparam int WEIGHT_W = 3;
    localparam int CNT_W    = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                enable;
    logic [WEIGHT_W-1:0] w0, w1;
    logic                vc0_empty, vc1_empty;
    logic [DATA_W-1:0]   vc0_data, vc1_data;
    logic                af0, af1;
    logic                pop_vc0, pop_vc1, push_d0, push_d1, arb_idle;
    logic [DATA_W-1:0]   data_out;
    logic [CNT_W-1:0]    gcnt0, gcnt1;

    vc_arbiter #(.DATA_W(DATA_W), .DEST_BIT(DEST_BIT), .WEIGHT_W(WEIGHT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(rst_n), .enable(enable),
        .weight_vc0(w0), .weight_vc1(w1),
        .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
        .vc0_data(vc0_data), .vc1_data(vc1_data),
        .d0_almost_full(af0), .d1_almost_full(af1),
        .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
        .push_d0(push_d0), .push_d1(push_d1),
        .data_out(data_out), .arb_idle(arb_idle),
        .grant_cnt_vc0(gcnt0), .grant_cnt_vc1(gcnt1)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: either idle, or some VC owns the grant and has used
    // m_burst of its allowance.
    bit          m_on;
    int          m_owner, m_burst, m_last;
    bit          exp_p0, exp_p1;
    logic [5:0]  exp_dout;
    int          g0, g1;

    // Stimulus FIFOs (used by the directed sequences).
    bit          use_q;
    logic [5:0]  q0[$];
    logic [5:0]  q1[$];

    // Observations of the DUT for sequence-level checks.
    int          last_dut_pop;
    logic        last_dut_idle;
    int          n_dut_pop0, n_dut_pop1;
    bit          log_en;
    int          pop_log[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply_q();
        vc0_empty = (q0.size() == 0);
        vc1_empty = (q1.size() == 0);
        vc0_data  = (q0.size() != 0) ? q0[0] : 6'd0;
        vc1_data  = (q1.size() != 0) ? q1[0] : 6'd0;
    endtask

    task automatic model_reset();
        m_on = 1'b0; m_owner = 0; m_burst = 0; m_last = 1;
        exp_p0 = 1'b0; exp_p1 = 1'b0; exp_dout = 6'd0;
        g0 = 0; g1 = 0;
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_pop0", pop_vc0, 0);
        chk("rst_pop1", pop_vc1, 0);
        chk("rst_push0", push_d0, 0);
        chk("rst_push1", push_d1, 0);
        chk("rst_data", data_out, 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One cycle: compare the DUT against the model at the falling edge, then
    // advance the model to the next cycle.
    task automatic tick();
        int ep, o, wo, wt0, wt1;
        bit e0, e1, eo, ex;
        logic [5:0] word;
        @(negedge clk);
        e0  = !vc0_empty && !(vc0_data[DEST_BIT] ? af1 : af0);
        e1  = !vc1_empty && !(vc1_data[DEST_BIT] ? af1 : af0);
        wt0 = (w0 == 3'd0) ? 1 : int'(w0);
        wt1 = (w1 == 3'd0) ? 1 : int'(w1);
        ep  = -1;
        if (!enable) begin
            m_on = 1'b0;
        end else if (!m_on) begin
            m_on = 1'b1; m_owner = 1 - m_last; m_burst = 0;
        end else begin
            o  = m_owner;
            eo = o ? e1 : e0;
            ex = o ? e0 : e1;
            wo = o ? wt1 : wt0;
            if (eo) begin
                ep = o;
                m_burst++;
                if (m_burst >= wo) begin
                    m_burst = 0;
                    if (ex) m_owner = 1 - o;
                end
            end else if (ex) begin
                ep = 1 - o; m_owner = 1 - o; m_burst = 1;
            end
        end
        chk("pop_vc0", pop_vc0, (ep == 0));
        chk("pop_vc1", pop_vc1, (ep == 1));
        chk("push_d0", push_d0, exp_p0);
        chk("push_d1", push_d1, exp_p1);
        chk("data_out", data_out, exp_dout);
        chk("arb_idle", arb_idle, (ep < 0) && !exp_p0 && !exp_p1);
`ifdef ARB_STATS_EN
        chk("gcnt0", gcnt0, g0);
        chk("gcnt1", gcnt1, g1);
`else
        chk("gcnt0", gcnt0, 0);
        chk("gcnt1", gcnt1, 0);
`endif
        last_dut_pop  = pop_vc0 ? 0 : (pop_vc1 ? 1 : -1);
        last_dut_idle = arb_idle;
        if (pop_vc0) n_dut_pop0++;
        if (pop_vc1) n_dut_pop1++;
        if (log_en && last_dut_pop >= 0) pop_log.push_back(last_dut_pop);
        if (ep >= 0) begin
            word     = ep ? vc1_data : vc0_data;
            exp_p0   = !word[DEST_BIT];
            exp_p1   = word[DEST_BIT];
            exp_dout = word;
            m_last   = ep;
            if (ep == 0 && g0 < (1 << CNT_W) - 1) g0++;
            if (ep == 1 && g1 < (1 << CNT_W) - 1) g1++;
            if (use_q) begin
                if (ep == 0) void'(q0.pop_front());
                else         void'(q1.pop_front());
            end
        end else begin
            exp_p0 = 1'b0;
            exp_p1 = 1'b0;
        end
        @(posedge clk); #1;
        if (use_q) apply_q();
    endtask

    typedef struct {
        string      name;
        logic       en, e0, e1;
        logic [5:0] d0, d1;
        logic       af0, af1;
        logic       xp0, xp1, xq0, xq1;
        logic [5:0] xd;
    } vec_t;

    vec_t vecs[9];
    int   exp_order[12];

    initial begin
        //            name         en    e0    e1    d0     d1     af0   af1   pop0  pop1  psh0  psh1  data
        vecs[0] = '{"both_elig",  1'b1, 1'b0, 1'b0, 6'h05, 6'h13, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'h05};
        vecs[1] = '{"vc0_empty",  1'b1, 1'b1, 1'b0, 6'h05, 6'h13, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'h13};
        vecs[2] = '{"vc0_af1",    1'b1, 1'b0, 1'b0, 6'h10, 6'h03, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'h03};
        vecs[3] = '{"vc0_af0",    1'b1, 1'b0, 1'b0, 6'h05, 6'h1A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'h1A};
        vecs[4] = '{"none",       1'b1, 1'b1, 1'b1, 6'h05, 6'h13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00};
        vecs[5] = '{"vc1_empty",  1'b1, 1'b0, 1'b1, 6'h2F, 6'h13, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'h2F};
        vecs[6] = '{"disabled",   1'b0, 1'b0, 1'b0, 6'h05, 6'h13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00};
        vecs[7] = '{"both_block", 1'b1, 1'b0, 1'b0, 6'h05, 6'h13, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00};
        vecs[8] = '{"dest_sel",   1'b1, 1'b0, 1'b0, 6'h3F, 6'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'h3F};
        exp_order = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 1};

        rst_n = 1'b0; enable = 1'b0; w0 = 3'd1; w1 = 3'd1;
        vc0_empty = 1'b1; vc1_empty = 1'b1; vc0_data = 6'd0; vc1_data = 6'd0;
        af0 = 1'b0; af1 = 1'b0; use_q = 1'b0; log_en = 1'b0;
        n_dut_pop0 = 0; n_dut_pop1 = 0; last_dut_pop = -1; last_dut_idle = 1'b0;
        model_reset();
        @(posedge clk); #1;

        // Table: from a fresh reset the first grant belongs to VC0.
        for (int i = 0; i < 9; i++) begin
            do_reset();
            enable = 1'b1; vc0_empty = 1'b1; vc1_empty = 1'b1; af0 = 1'b0; af1 = 1'b0;
            @(posedge clk); #1;
            enable = vecs[i].en; vc0_empty = vecs[i].e0; vc1_empty = vecs[i].e1;
            vc0_data = vecs[i].d0; vc1_data = vecs[i].d1; af0 = vecs[i].af0; af1 = vecs[i].af1;
            @(negedge clk);
            chk({vecs[i].name, "_pop0"}, pop_vc0, vecs[i].xp0);
            chk({vecs[i].name, "_pop1"}, pop_vc1, vecs[i].xp1);
            chk({vecs[i].name, "_idle"}, arb_idle, !(vecs[i].xp0 || vecs[i].xp1));
            @(posedge clk); #1;
            vc0_empty = 1'b1; vc1_empty = 1'b1;
            @(negedge clk);
            chk({vecs[i].name, "_push0"}, push_d0, vecs[i].xq0);
            chk({vecs[i].name, "_push1"}, push_d1, vecs[i].xq1);
            chk({vecs[i].name, "_data"}, data_out, vecs[i].xd);
            @(posedge clk); #1;
        end
        af0 = 1'b0; af1 = 1'b0;

        // Weights 2:1, six D0 words in each VC.
        do_reset();
        w0 = 3'd2; w1 = 3'd1; use_q = 1'b1; log_en = 1'b1;
        q0 = '{}; q1 = '{};
        for (int i = 0; i < 6; i++) begin
            q0.push_back(6'(i + 1));
            q1.push_back(6'(32 + i));
        end
        apply_q(); enable = 1'b1;
        for (int i = 0; i < 40 && (q0.size() + q1.size()) > 0; i++) tick();
        chk("wrr_drained", q0.size() + q1.size(), 0);
        tick();
        log_en = 1'b0;
        chk("wrr_count", pop_log.size(), 12);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("wrr_order%0d", i), (i < pop_log.size()) ? pop_log[i] : -1, exp_order[i]);
        end

        // VC0 headed for a paused D1 must not block VC1.
        do_reset();
        w0 = 3'd1; w1 = 3'd1; af1 = 1'b1;
        q0 = '{6'b010000};
        q1 = '{6'b000011, 6'b000011, 6'b000011};
        apply_q(); n_dut_pop0 = 0; n_dut_pop1 = 0;
        for (int i = 0; i < 5; i++) tick();
        chk("hol_vc0_held", n_dut_pop0, 0);
        chk("hol_vc1_served", n_dut_pop1, 3);
        af1 = 1'b0;
        tick();
        chk("hol_vc0_resume", last_dut_pop, 0);
        tick();

        // Only VC1 busy: back-to-back pops with no bubbles.
        do_reset();
        q0 = '{}; q1 = '{};
        for (int i = 0; i < 8; i++) q1.push_back(6'(16 + i));
        apply_q();
        tick();
        n_dut_pop1 = 0;
        for (int i = 0; i < 8; i++) tick();
        chk("wc_vc1_pops", n_dut_pop1, 8);
        tick();

        // Disable mid-stream, then re-enable.
        do_reset();
        w0 = 3'd2; w1 = 3'd3;
        q0 = '{6'h01, 6'h12, 6'h03, 6'h14, 6'h05};
        q1 = '{6'h21, 6'h32, 6'h23, 6'h34, 6'h25};
        apply_q();
        for (int i = 0; i < 4; i++) tick();
        enable = 1'b0;
        tick();
        chk("dis_no_pop", last_dut_pop, -1);
        chk("dis_push_busy", last_dut_idle, 0);
        tick();
        chk("dis_idle", last_dut_idle, 1);
        enable = 1'b1;
        tick();
        tick();
        chk("reen_vc0_first", last_dut_pop, 0);
        tick();

        // Asynchronous reset between edges while a push is pending.
        do_reset();
        w0 = 3'd3; w1 = 3'd1;
        q0 = '{6'h07, 6'h08, 6'h09}; q1 = '{};
        apply_q();
        tick();
        tick();
        #1;
        chk("ar_push_pending", push_d0, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_push0", push_d0, 0);
        chk("ar_push1", push_d1, 0);
        chk("ar_data", data_out, 0);
        chk("ar_pop0", pop_vc0, 0);
        chk("ar_pop1", pop_vc1, 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Randomized run against the model.
        use_q = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            enable    = ($urandom_range(0, 9) != 0);
            w0        = 3'($urandom_range(0, 7));
            w1        = 3'($urandom_range(0, 7));
            vc0_empty = ($urandom_range(0, 3) == 0);
            vc1_empty = ($urandom_range(0, 3) == 0);
            vc0_data  = 6'($urandom_range(0, 63));
            vc1_data  = 6'($urandom_range(0, 63));
            af0       = ($urandom_range(0, 4) == 0);
            af1       = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 199) == 0) do_reset();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
